dsa_job_sequencer: RTL and testbench

//  Hardware master for the DSA register bus; replaces JTAG/host register poking for one downscale job.

---
 rtl/dsa_pkg.sv | 41 ++++
 rtl/dsa_out_skid.sv | 29 ++
 rtl/dsa_job_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dsa_job_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// Shared definitions for the DSA register-bus job sequencer: register map,
// STATUS bit positions, sequencer state encoding and the input word-count helper.
`timescale 1ns/1ps
package dsa_pkg;

    localparam logic [15:0] DSA_CTRL     = 16'h0000;
    localparam logic [15:0] DSA_STATUS   = 16'h0001;
    localparam logic [15:0] DSA_IMG_W    = 16'h0002;
    localparam logic [15:0] DSA_IMG_H    = 16'h0003;
    localparam logic [15:0] DSA_SCALE    = 16'h0004;
    localparam logic [15:0] DSA_IN_ADDR  = 16'h0020;
    localparam logic [15:0] DSA_IN_DATA  = 16'h0021;
    localparam logic [15:0] DSA_OUT_ADDR = 16'h0030;
    localparam logic [15:0] DSA_OUT_DATA = 16'h0031;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RDPTR,
        ST_READ
    } dsa_seq_state_e;

    // Packed 4-pixel words needed for a w x h image, capped at what the core can hold.
    function automatic logic [31:0] calc_in_words(input logic [15:0] w,
                                                  input logic [15:0] h,
                                                  input logic [31:0] max_words);
        logic [31:0] prod;
        logic [31:0] words;
        prod  = 32'(w) * 32'(h);
        words = (prod + 32'd3) >> 2;
        return (words > max_words) ? max_words : words;
    endfunction

endpackage

// File: rtl/dsa_out_skid.sv
// One-entry valid/ready holding register between OUT_DATA bus reads and the output stream.
`timescale 1ns/1ps
module dsa_out_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dsa_job_sequencer.sv
// Register-bus master that runs one DSA downscale job: configure, stream input,
// start, poll STATUS, then drain OUT_DATA into a valid/ready stream.
`timescale 1ns/1ps
module dsa_job_sequencer
    import dsa_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int IMG_MAX_W    = 32,
    parameter int IMG_MAX_H    = 32,
    parameter int IN_GAP       = 4,
    parameter int POLL_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [15:0]           job_in_w,
    input  logic [15:0]           job_in_h,
    input  logic [15:0]           job_scale,
    input  logic [15:0]           job_out_words,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  h_wr_en,
    output logic                  h_rd_en,
    output logic [ADDR_WIDTH-1:0] h_addr,
    output logic [31:0]           h_wdata,
    input  logic [31:0]           h_rdata,
    input  logic                  h_rvalid,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  err,
    output logic [31:0]           cyc_cnt
);

    localparam logic [31:0] MAX_WORDS = 32'((IMG_MAX_W * IMG_MAX_H + 3) >> 2);
    localparam logic [31:0] TMO_LAST  = 32'(POLL_TIMEOUT - 1);

    dsa_seq_state_e state;
    logic [15:0]    w_q, h_q, scale_q, out_words_q;
    logic [31:0]    words_left;
    logic [1:0]     cfg_idx;
    logic [7:0]     gap;
    logic [31:0]    tmo;
    logic [15:0]    rd_left;
    logic           last_pending;
    logic           rd_issue;
    logic           skid_load;

    assign job_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_LOAD) && (gap == 8'd0) && (words_left != 32'd0) && in_valid;

    // A read is in flight whenever h_rd_en is high, so a new one waits until the holding register will be free.
    assign rd_issue  = (state == ST_READ) && !h_rd_en && (rd_left != 16'd0) && (!out_valid || out_ready);
    assign skid_load = (state == ST_READ) && h_rd_en && h_rvalid;

    dsa_out_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .load_data (h_rdata),
        .load_last (last_pending),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            w_q          <= 16'd0;
            h_q          <= 16'd0;
            scale_q      <= 16'd0;
            out_words_q  <= 16'd0;
            words_left   <= 32'd0;
            cfg_idx      <= 2'd0;
            gap          <= 8'd0;
            tmo          <= 32'd0;
            rd_left      <= 16'd0;
            last_pending <= 1'b0;
            h_wr_en      <= 1'b0;
            h_rd_en      <= 1'b0;
            h_addr       <= '0;
            h_wdata      <= 32'd0;
            done_pulse   <= 1'b0;
            err          <= 1'b0;
            cyc_cnt      <= 32'd0;
        end else begin
            h_wr_en    <= 1'b0;
            h_rd_en    <= 1'b0;
            done_pulse <= 1'b0;
            if (state != ST_IDLE && cyc_cnt != 32'hFFFF_FFFF)
                cyc_cnt <= cyc_cnt + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        w_q         <= job_in_w;
                        h_q         <= job_in_h;
                        scale_q     <= job_scale;
                        out_words_q <= job_out_words;
                        cyc_cnt     <= 32'd0;
                        if (job_in_w == 16'd0 || job_in_h == 16'd0 || job_scale == 16'd0) begin
                            err        <= 1'b1;
                            done_pulse <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            words_left <= calc_in_words(job_in_w, job_in_h, MAX_WORDS);
                            cfg_idx    <= 2'd0;
                            state      <= ST_CFG;
                        end
                    end
                end
                ST_CFG: begin
                    h_wr_en <= 1'b1;
                    case (cfg_idx)
                        2'd0:    begin h_addr <= ADDR_WIDTH'(DSA_IMG_W);   h_wdata <= 32'(w_q);     end
                        2'd1:    begin h_addr <= ADDR_WIDTH'(DSA_IMG_H);   h_wdata <= 32'(h_q);     end
                        2'd2:    begin h_addr <= ADDR_WIDTH'(DSA_SCALE);   h_wdata <= 32'(scale_q); end
                        default: begin h_addr <= ADDR_WIDTH'(DSA_IN_ADDR); h_wdata <= 32'd0;        end
                    endcase
                    cfg_idx <= cfg_idx + 2'd1;
                    if (cfg_idx == 2'd3) begin
                        gap   <= 8'd0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (gap != 8'd0)
                        gap <= gap - 8'd1;
                    if (in_ready) begin
                        h_wr_en    <= 1'b1;
                        h_addr     <= ADDR_WIDTH'(DSA_IN_DATA);
                        h_wdata    <= in_data;
                        gap        <= 8'(IN_GAP);
                        words_left <= words_left - 32'd1;
                    end else if (words_left == 32'd0 && gap == 8'd0) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    h_wr_en <= 1'b1;
                    h_addr  <= ADDR_WIDTH'(DSA_CTRL);
                    h_wdata <= 32'd1;
                    tmo     <= 32'd0;
                    state   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    tmo <= tmo + 32'd1;
                    if (tmo == TMO_LAST) begin
                        err        <= 1'b1;
                        done_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        h_rd_en <= 1'b1;
                        h_addr  <= ADDR_WIDTH'(DSA_STATUS);
                        if (h_rd_en && h_rvalid) begin
                            if (state == ST_WAIT_BUSY && h_rdata[STATUS_BUSY_BIT]) begin
                                state <= ST_WAIT_DONE;
                            end else if ((state == ST_WAIT_BUSY && h_rdata[STATUS_DONE_BIT]) ||
                                         (state == ST_WAIT_DONE && !h_rdata[STATUS_BUSY_BIT])) begin
                                h_rd_en <= 1'b0;
                                state   <= ST_RDPTR;
                            end
                        end
                    end
                end
                ST_RDPTR: begin
                    if (out_words_q == 16'd0) begin
                        done_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        h_wr_en <= 1'b1;
                        h_addr  <= ADDR_WIDTH'(DSA_OUT_ADDR);
                        h_wdata <= 32'd0;
                        rd_left <= out_words_q;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        h_rd_en      <= 1'b1;
                        h_addr       <= ADDR_WIDTH'(DSA_OUT_DATA);
                        rd_left      <= rd_left - 16'd1;
                        last_pending <= (rd_left == 16'd1);
                    end
                    if (out_valid && out_ready && out_last) begin
                        done_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsa_job_sequencer.sv
// Self-checking bench: behavioural DSA register model plus job-level reference of the expected bus traffic and output stream.
`timescale 1ns/1ps
module tb_dsa_job_sequencer;
    import dsa_pkg::*;

    localparam int POLL_TO   = 100;
    localparam int GAP       = 4;
    localparam int MAX_WORDS = (32 * 32 + 3) / 4;

    logic        clk, rst_n;
    logic        job_valid, job_ready;
    logic [15:0] job_in_w, job_in_h, job_scale, job_out_words;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        h_wr_en, h_rd_en, h_rvalid;
    logic [15:0] h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        busy, done_pulse, err;
    logic [31:0] cyc_cnt;

    dsa_job_sequencer #(
        .ADDR_WIDTH   (16),
        .IMG_MAX_W    (32),
        .IMG_MAX_H    (32),
        .IN_GAP       (GAP),
        .POLL_TIMEOUT (POLL_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_in_w      (job_in_w),
        .job_in_h      (job_in_h),
        .job_scale     (job_scale),
        .job_out_words (job_out_words),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .h_wr_en       (h_wr_en),
        .h_rd_en       (h_rd_en),
        .h_addr        (h_addr),
        .h_wdata       (h_wdata),
        .h_rdata       (h_rdata),
        .h_rvalid      (h_rvalid),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .err           (err),
        .cyc_cnt       (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DSA core model state and bus-traffic monitors
    logic        core_busy = 1'b0, core_done = 1'b0;
    int          busy_left = 0;
    int          latency = 0;
    bit          stuck = 1'b0;
    logic [31:0] out_seed = 32'd0;
    int          out_ptr = 0;
    logic [47:0] wr_log[$];
    int          tb_cyc = 0, rd31_cnt = 0, poll_cnt = 0, both_cnt = 0, gap_viol = 0, in21_cnt = 0, last_in_cyc = 0;

    function automatic logic [31:0] out_word(input logic [31:0] seed, input int idx);
        return seed ^ (32'(idx) * 32'h9E37_79B1) ^ 32'(idx);
    endfunction

    always_comb begin
        h_rvalid = h_rd_en;
        h_rdata  = 32'd0;
        if (h_addr == DSA_STATUS)   h_rdata = {30'd0, core_done, core_busy};
        if (h_addr == DSA_OUT_DATA) h_rdata = out_word(out_seed, out_ptr);
    end

    always @(posedge clk) begin
        tb_cyc++;
        if (h_wr_en && h_rd_en) both_cnt++;
        if (core_busy && !stuck && busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
            end
        end
        if (h_wr_en) begin
            wr_log.push_back({h_addr, h_wdata});
            if (h_addr == DSA_IN_DATA) begin
                if (in21_cnt > 0 && (tb_cyc - last_in_cyc) < GAP + 1) gap_viol++;
                last_in_cyc = tb_cyc;
                in21_cnt++;
            end
            if (h_addr == DSA_CTRL && h_wdata[0]) begin
                core_done <= 1'b0;
                if (stuck) begin
                    core_busy <= 1'b1;
                end else if (latency == 0) begin
                    core_busy <= 1'b0;
                    core_done <= 1'b1;
                end else begin
                    core_busy <= 1'b1;
                    busy_left <= latency;
                end
            end
            if (h_addr == DSA_OUT_ADDR) out_ptr <= 0;
        end
        if (h_rd_en) begin
            if (h_addr == DSA_OUT_DATA) begin
                rd31_cnt++;
                out_ptr <= out_ptr + 1;
            end
            if (h_addr == DSA_STATUS) poll_cnt++;
        end
    end

    // Per-job bookkeeping shared by the stimulus processes
    logic [31:0] in_q[$];
    logic [31:0] got_data[$];
    bit          got_last[$];
    logic [47:0] exp_wr[$];
    int          exp_in, acc_cyc, done_cyc, feed_sent, stall_cnt, in21_mark;
    int          hold_state, hold_cnt, hold_unstable, mism;
    logic [31:0] hold_data, cyc_done;
    bit          finished, done_seen, aborted, err_done, bad;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int w, input int h, input int s, input int o,
                                 input int lat, input bit stuck_mode, input bit stall,
                                 input bit hold, input int abort_n);
        longint pix;
        wr_log.delete(); got_data.delete(); got_last.delete(); in_q.delete(); exp_wr.delete();
        rd31_cnt = 0; poll_cnt = 0; both_cnt = 0; gap_viol = 0; in21_cnt = 0;
        latency = lat; stuck = stuck_mode; out_seed = $urandom;
        finished = 0; done_seen = 0; aborted = 0; hold_state = 0; feed_sent = 0; stall_cnt = 0;
        bad = (w == 0 || h == 0 || s == 0);
        pix = longint'(w) * longint'(h);
        exp_in = bad ? 0 : int'(((pix + 3) / 4 > MAX_WORDS) ? MAX_WORDS : (pix + 3) / 4);
        for (int i = 0; i < exp_in; i++) in_q.push_back($urandom);

        @(negedge clk);
        job_in_w = 16'(w); job_in_h = 16'(h); job_scale = 16'(s); job_out_words = 16'(o);
        job_valid = 1'b1;
        #1 checkOutput("job_ready_idle", job_ready, 1);
        @(negedge clk);
        acc_cyc = tb_cyc;
        job_valid = 1'b0;

        fork
            begin
                for (int i = 0; i < 4000; i++) begin
                    #1;
                    if (done_pulse) begin
                        done_seen = 1; done_cyc = tb_cyc; err_done = err; cyc_done = cyc_cnt;
                        break;
                    end
                    if (abort_n > 0 && in21_cnt >= abort_n) begin
                        aborted = 1;
                        break;
                    end
                    @(negedge clk);
                end
                finished = 1;
            end
            begin
                while (!finished) begin
                    if (stall && feed_sent == 2 && stall_cnt < 20) begin
                        in_valid = 1'b0;
                        stall_cnt++;
                        if (stall_cnt == 5) in21_mark = in21_cnt;
                        if (stall_cnt == 20) checkOutput("stall_no_in_write", 64'(in21_cnt - in21_mark), 0);
                    end else begin
                        in_valid = (feed_sent < exp_in);
                        in_data  = (feed_sent < exp_in) ? in_q[feed_sent] : 32'd0;
                    end
                    #2;
                    if (in_valid && in_ready) feed_sent++;
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                while (!finished) begin
                    #1;
                    if (hold && hold_state == 0 && out_valid) begin
                        hold_state = 1; hold_cnt = 0; hold_data = out_data; hold_unstable = 0;
                    end
                    if (hold_state == 1) begin
                        out_ready = 1'b0;
                        if (!out_valid || out_data !== hold_data) hold_unstable++;
                        hold_cnt++;
                        if (hold_cnt == 10) begin
                            checkOutput("hold_data_stable", 64'(hold_unstable), 0);
                            checkOutput("hold_outstanding_reads", 64'(rd31_cnt - got_data.size()), 1);
                            hold_state = 2;
                        end
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    #1;
                    if (out_valid && out_ready) begin
                        got_data.push_back(out_data);
                        got_last.push_back(out_last);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b0;
            end
        join

        if (!aborted) begin
            checkOutput("done_seen", done_seen, 1);
            checkOutput("err", err_done, (bad || stuck_mode) ? 1 : 0);
            checkOutput("cyc_cnt", cyc_done, 64'(done_cyc - acc_cyc));
            checkOutput("in_words_sent", 64'(feed_sent), 64'(exp_in));
            if (!bad) begin
                exp_wr.push_back({DSA_IMG_W, 32'(w)});
                exp_wr.push_back({DSA_IMG_H, 32'(h)});
                exp_wr.push_back({DSA_SCALE, 32'(s)});
                exp_wr.push_back({DSA_IN_ADDR, 32'd0});
                foreach (in_q[i]) exp_wr.push_back({DSA_IN_DATA, in_q[i]});
                exp_wr.push_back({DSA_CTRL, 32'd1});
                if (!stuck_mode && o != 0) exp_wr.push_back({DSA_OUT_ADDR, 32'd0});
            end
            checkOutput("wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
            mism = 0;
            foreach (exp_wr[i]) if (i >= wr_log.size() || wr_log[i] !== exp_wr[i]) mism++;
            checkOutput("wr_seq_mismatches", 64'(mism), 0);
            checkOutput("out_count", 64'(got_data.size()), (bad || stuck_mode) ? 0 : 64'(o));
            checkOutput("out_data_reads", 64'(rd31_cnt), (bad || stuck_mode) ? 0 : 64'(o));
            mism = 0;
            foreach (got_data[i])
                if (got_data[i] !== out_word(out_seed, i) || got_last[i] !== (i == o - 1)) mism++;
            checkOutput("out_word_mismatches", 64'(mism), 0);
            checkOutput("strobe_overlap", 64'(both_cnt), 0);
            checkOutput("in_gap_violations", 64'(gap_viol), 0);
            if (stuck_mode)
                checkOutput("timeout_poll_count", (poll_cnt >= POLL_TO - 1 && poll_cnt <= POLL_TO), 1);
            if (bad) begin
                checkOutput("reject_latency", (done_cyc - acc_cyc) <= 1, 1);
                checkOutput("reject_no_reads", 64'(poll_cnt + rd31_cnt), 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_in_w = '0; job_in_h = '0; job_scale = '0; job_out_words = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl_zero", {h_wr_en, h_rd_en, busy, out_valid, out_last, done_pulse, err, in_ready}, 0);
        checkOutput("reset_data_zero", {h_addr, h_wdata, cyc_cnt}, 0);
        checkOutput("reset_job_ready", job_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic 4x4 job");
        applyStimulus(4, 4, 16'h0080, 4, 6, 0, 0, 0, 0);
        $display("[TB] input stall mid-load");
        applyStimulus(8, 4, 16'h0100, 3, 10, 0, 1, 0, 0);
        $display("[TB] output backpressure");
        applyStimulus(4, 4, 16'h0080, 5, 5, 0, 0, 1, 0);
        $display("[TB] stuck-busy timeout");
        applyStimulus(4, 4, 16'h0080, 2, 0, 1, 0, 0, 0);
        $display("[TB] reject on zero scale");
        applyStimulus(4, 4, 0, 3, 4, 0, 0, 0, 0);
        $display("[TB] reset during load");
        applyStimulus(4, 4, 16'h0080, 2, 4, 0, 0, 0, 2);
        checkOutput("abort_reached", aborted, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("abort_ctrl_zero", {h_wr_en, h_rd_en, busy, out_valid, done_pulse, err, in_ready}, 0);
        checkOutput("abort_data_zero", {h_addr, h_wdata, cyc_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(3, 5, 16'h0090, 3, 7, 0, 0, 0, 0);
        $display("[TB] fast core");
        applyStimulus(5, 3, 16'h0040, 2, 0, 0, 0, 0, 0);
        $display("[TB] zero output words");
        applyStimulus(2, 2, 16'h0080, 0, 3, 0, 0, 0, 0);
        $display("[TB] input word clamp");
        applyStimulus(64, 64, 16'h0200, 1, 8, 0, 0, 0, 0);
        $display("[TB] random jobs");
        for (int k = 0; k < 3; k++)
            applyStimulus($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 16'hFFFF),
                          $urandom_range(1, 6), $urandom_range(1, 40), 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
